mpemu_mac: RTL and testbench

//  Pipelined signed fractional (Q1.W-1) shift-add multiply-accumulate; next generation of mpemu.

---
 rtl/mpemu_mac_pkg.sv | 20 ++
 rtl/mpemu_mac_stage.sv | 53 +++++
 rtl/mpemu_mac.sv | 155 +++++++++++++++
 tb/tb_mpemu_mac.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mpemu_mac_pkg.sv
// Shared types and helpers for the mpemu_mac pipelined fractional multiply-accumulate.
package mpemu_mac_pkg;

    typedef enum logic {
        RND_FLOOR   = 1'b0,
        RND_HALF_UP = 1'b1
    } rnd_mode_t;

    typedef struct packed {
        logic      first;
        logic      last;
        rnd_mode_t rnd;
    } flags_t;

    // Clocks from a sampled last_i to the matching valid_o pulse.
    function automatic int unsigned mac_latency(input int unsigned w, input int unsigned bps);
        return w / bps + 2;
    endfunction

endpackage

// File: rtl/mpemu_mac_stage.sv
// One shift-add step: retires BPS multiplier bits into the running partial product.
module mpemu_stage
    import mpemu_mac_pkg::*;
#(
    parameter int unsigned W   = 24,
    parameter int unsigned BPS = 4,
    parameter int unsigned IDX = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    up_valid,
    input  flags_t                  up_flags,
    input  logic [W-1:0]            up_mpcand,
    input  logic [W-1:0]            up_mplier,
    input  logic signed [2*W-1:0]   up_psum,
    output logic                    dn_valid,
    output flags_t                  dn_flags,
    output logic [W-1:0]            dn_mpcand,
    output logic [W-1:0]            dn_mplier,
    output logic signed [2*W-1:0]   dn_psum
);

    // The most significant group carries the sign of the multiplier.
    localparam bit TOP = (IDX == W / BPS - 1);

    logic [BPS-1:0]          grp;
    logic signed [2*W-1:0]   cand_x;
    logic signed [2*W-1:0]   grp_x;
    logic signed [2*W-1:0]   term;

    always_comb begin
        grp    = up_mplier[IDX*BPS +: BPS];
        cand_x = {{W{up_mpcand[W-1]}}, up_mpcand};
        grp_x  = {{(2*W-BPS){TOP ? grp[BPS-1] : 1'b0}}, grp};
        term   = (cand_x * grp_x) <<< (IDX * BPS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dn_valid <= 1'b0;
        end else begin
            dn_valid <= up_valid;
        end
    end

    always_ff @(posedge clk) begin
        dn_flags  <= up_flags;
        dn_mpcand <= up_mpcand;
        dn_mplier <= up_mplier;
        dn_psum   <= up_psum + term;
    end

endmodule

// File: rtl/mpemu_mac.sv
// Pipelined signed Q1.(W-1) shift-add multiply-accumulate with framing, rounding and saturation.
module mpemu_mac
    import mpemu_mac_pkg::*;
#(
    parameter int unsigned W     = 24,
    parameter int unsigned BPS   = 4,
    parameter int unsigned GUARD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  logic         first_i,
    input  logic         last_i,
    input  logic         round_i,
    input  logic [W-1:0] mpcand_i,
    input  logic [W-1:0] mplier_i,
    output logic         valid_o,
    output logic [W-1:0] mprod_o,
    output logic         sat_o
);

    localparam int unsigned NST = W / BPS;
    localparam int unsigned AW  = 2 * W - 1 + GUARD;
    localparam logic signed [AW:0] HALF = (AW + 1)'(1) << (W - 2);
    localparam logic signed [AW:0] MAXV = (AW + 1)'((64'd1 << (W - 1)) - 64'd1);
    localparam logic signed [AW:0] MINV = ~MAXV;

    // Input register (stage 0)
    logic                  in_valid;
    flags_t                in_flags;
    logic [W-1:0]          in_mpcand;
    logic [W-1:0]          in_mplier;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid <= 1'b0;
        end else begin
            in_valid <= valid_i;
        end
    end

    always_ff @(posedge clk) begin
        in_flags  <= '{first: first_i, last: last_i, rnd: rnd_mode_t'(round_i)};
        in_mpcand <= mpcand_i;
        in_mplier <= mplier_i;
    end

    // Shift-add chain
    logic [NST-1:0]                 v_s;
    flags_t [NST-1:0]               flg_s;
    logic [NST-1:0][W-1:0]          cand_s;
    logic [NST-1:0][W-1:0]          mplier_s;
    logic [NST-1:0][2*W-1:0]        psum_s;

    for (genvar k = 0; k < NST; k++) begin : g_stage
        if (k == 0) begin : g_head
            mpemu_stage #(.W(W), .BPS(BPS), .IDX(k)) u_stage (
                .clk       (clk),
                .rst       (rst),
                .up_valid  (in_valid),
                .up_flags  (in_flags),
                .up_mpcand (in_mpcand),
                .up_mplier (in_mplier),
                .up_psum   ('0),
                .dn_valid  (v_s[k]),
                .dn_flags  (flg_s[k]),
                .dn_mpcand (cand_s[k]),
                .dn_mplier (mplier_s[k]),
                .dn_psum   (psum_s[k])
            );
        end else begin : g_body
            mpemu_stage #(.W(W), .BPS(BPS), .IDX(k)) u_stage (
                .clk       (clk),
                .rst       (rst),
                .up_valid  (v_s[k-1]),
                .up_flags  (flg_s[k-1]),
                .up_mpcand (cand_s[k-1]),
                .up_mplier (mplier_s[k-1]),
                .up_psum   (psum_s[k-1]),
                .dn_valid  (v_s[k]),
                .dn_flags  (flg_s[k]),
                .dn_mpcand (cand_s[k]),
                .dn_mplier (mplier_s[k]),
                .dn_psum   (psum_s[k])
            );
        end
    end

    logic unused_tail;
    assign unused_tail = ^{cand_s[NST-1], mplier_s[NST-1]};

    // Accumulate stage: acc holds the open partial sum, fin the completed one awaiting emit.
    logic signed [2*W-1:0] prod;
    logic signed [AW-1:0]  prod_x;
    logic signed [AW-1:0]  acc_sum;
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  fin;
    rnd_mode_t             fin_rnd;
    logic                  fin_valid;

    always_comb begin
        prod    = psum_s[NST-1];
        prod_x  = AW'(prod);
        acc_sum = flg_s[NST-1].first ? prod_x : acc + prod_x;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            fin_valid <= 1'b0;
        end else begin
            fin_valid <= v_s[NST-1] & flg_s[NST-1].last;
            if (v_s[NST-1]) begin
                acc     <= flg_s[NST-1].last ? '0 : acc_sum;
                fin     <= acc_sum;
                fin_rnd <= flg_s[NST-1].rnd;
            end
        end
    end

    // Emit stage: optional half-LSB bias, floor shift, clamp to Q1.(W-1)
    logic signed [AW:0] biased;
    logic signed [AW:0] shifted;
    logic [W-1:0]       res;
    logic               clamp;

    always_comb begin
        biased  = (AW + 1)'(fin) + ((fin_rnd == RND_HALF_UP) ? HALF : '0);
        shifted = biased >>> (W - 1);
        clamp   = 1'b1;
        if (shifted > MAXV) begin
            res = {1'b0, {(W-1){1'b1}}};
        end else if (shifted < MINV) begin
            res = {1'b1, {(W-1){1'b0}}};
        end else begin
            res   = shifted[W-1:0];
            clamp = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            mprod_o <= '0;
            sat_o   <= 1'b0;
        end else begin
            valid_o <= fin_valid;
            if (fin_valid) begin
                mprod_o <= res;
                sat_o   <= clamp;
            end
        end
    end

endmodule

// File: tb/tb_mpemu_mac.sv
// Self-checking bench for mpemu_mac: directed vector table, framed sequences, randomized model check.
module tb_mpemu_mac;
    import mpemu_mac_pkg::*;

    localparam int W   = 24;
    localparam int LAT = int'(mac_latency(24, 4));
    localparam longint PER = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_i = 1'b0, first_i = 1'b0, last_i = 1'b0, round_i = 1'b0;
    logic [W-1:0] mpcand_i = '0, mplier_i = '0;
    logic         valid_o;
    logic [W-1:0] mprod_o;
    logic         sat_o;

    mpemu_mac #(.W(W), .BPS(4), .GUARD(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .first_i  (first_i),
        .last_i   (last_i),
        .round_i  (round_i),
        .mpcand_i (mpcand_i),
        .mplier_i (mplier_i),
        .valid_o  (valid_o),
        .mprod_o  (mprod_o),
        .sat_o    (sat_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] p;
        logic         s;
        longint       due;
        int           id;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         rnd;
        logic [W-1:0] p;
        logic         s;
    } vec_t;

    exp_t   q[$];
    exp_t   mon_e;
    int     pass_cnt = 0;
    int     total = 0;
    int     id_cnt = 0;
    longint t_drv = 0;
    longint macc = 0;
    logic [W-1:0] last_p = '0;
    logic         last_s = 1'b0;

    function automatic void chk(input string name, input bit ok,
                                input logic [63:0] act, input logic [63:0] req);
        total++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endfunction

    // Monitor: reset state, in-order results with exact latency, hold while idle.
    always @(negedge clk) begin
        if (rst) begin
            chk("reset state", {valid_o, sat_o, mprod_o} == '0, {valid_o, sat_o, mprod_o}, 0);
            last_p = '0;
            last_s = 1'b0;
        end else if (valid_o) begin
            chk("spurious valid_o", q.size() != 0, {sat_o, mprod_o}, q.size());
            if (q.size() != 0) begin
                mon_e = q.pop_front();
                chk($sformatf("result #%0d", mon_e.id), {sat_o, mprod_o} == {mon_e.s, mon_e.p},
                    {sat_o, mprod_o}, {mon_e.s, mon_e.p});
                chk($sformatf("latency #%0d", mon_e.id), longint'($time) == mon_e.due,
                    $time, mon_e.due);
            end
            last_p = mprod_o;
            last_s = sat_o;
        end else begin
            chk("hold", {sat_o, mprod_o} == {last_s, last_p}, {sat_o, mprod_o}, {last_s, last_p});
        end
    end

    task automatic drive(input bit v, input bit f, input bit l, input bit r,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        t_drv = $time;
        #1;
        valid_i = v; first_i = f; last_i = l; round_i = r;
        mpcand_i = a; mplier_i = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, W'($urandom), W'($urandom));
    endtask

    task automatic expect_out(input logic [W-1:0] p, input logic s);
        q.push_back('{p: p, s: s, due: t_drv + (LAT + 1) * PER, id: id_cnt});
        id_cnt++;
    endtask

    // Reference: exact integer arithmetic on the Q-format values.
    function automatic void ref_emit(input longint acc, input bit r,
                                     output logic [W-1:0] p, output logic s);
        longint t, v, hi, lo;
        hi = (longint'(1) <<< (W - 1)) - 1;
        lo = -(longint'(1) <<< (W - 1));
        t  = acc + (r ? (longint'(1) <<< (W - 2)) : longint'(0));
        v  = t >>> (W - 1);
        s  = 1'b1;
        if (v > hi)      p = {1'b0, {(W-1){1'b1}}};
        else if (v < lo) p = {1'b1, {(W-1){1'b0}}};
        else begin
            p = v[W-1:0];
            s = 1'b0;
        end
    endfunction

    task automatic model_sample(input bit v, input bit f, input bit l, input bit r,
                                input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        logic [W-1:0] p;
        logic s;
        drive(v, f, l, r, a, b);
        if (v) begin
            sa = $signed(a);
            sb = $signed(b);
            macc = f ? sa * sb : macc + sa * sb;
            if (l) begin
                ref_emit(macc, r, p, s);
                expect_out(p, s);
                macc = 0;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        valid_i = 1'b0;
        q.delete();
        macc = 0;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return {1'b1, {(W-1){1'b0}}};
            1:       return {1'b0, {(W-1){1'b1}}};
            2:       return '0;
            default: return W'($urandom);
        endcase
    endfunction

    vec_t vt[7];

    initial begin
        vt[0] = '{a: 24'h100000, b: 24'h123456, rnd: 0, p: 24'h02468a, s: 0};
        vt[1] = '{a: 24'h123456, b: 24'h100000, rnd: 0, p: 24'h02468a, s: 0};
        vt[2] = '{a: 24'hffffff, b: 24'h400000, rnd: 0, p: 24'hffffff, s: 0};
        vt[3] = '{a: 24'hffffff, b: 24'h400000, rnd: 1, p: 24'h000000, s: 0};
        vt[4] = '{a: 24'h800000, b: 24'h800000, rnd: 0, p: 24'h7fffff, s: 1};
        vt[5] = '{a: 24'h7fffff, b: 24'h7fffff, rnd: 1, p: 24'h7ffffe, s: 0};
        vt[6] = '{a: 24'h800000, b: 24'h7fffff, rnd: 0, p: 24'h800001, s: 0};

        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;

        // Single multiplies from the table, issued back to back
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, 1, vt[i].rnd, vt[i].a, vt[i].b);
            expect_out(vt[i].p, vt[i].s);
        end
        idle(LAT + 2);

        // Framed accumulation: 3 and 4 terms of 0.25
        drive(1, 1, 0, 0, 24'h400000, 24'h400000);
        drive(1, 0, 0, 0, 24'h400000, 24'h400000);
        drive(1, 0, 1, 0, 24'h400000, 24'h400000);
        expect_out(24'h600000, 0);
        drive(1, 1, 0, 0, 24'h400000, 24'h400000);
        drive(1, 0, 0, 0, 24'h400000, 24'h400000);
        drive(1, 0, 0, 0, 24'h400000, 24'h400000);
        drive(1, 0, 1, 0, 24'h400000, 24'h400000);
        expect_out(24'h7fffff, 1);
        // last without first after a last starts from zero
        drive(1, 0, 1, 0, 24'h400000, 24'h400000);
        expect_out(24'h200000, 0);
        // first while a frame is open discards the old partial sum
        drive(1, 1, 0, 0, 24'h7fffff, 24'h7fffff);
        drive(1, 1, 1, 0, 24'h400000, 24'h400000);
        expect_out(24'h200000, 0);
        // bubble inside a frame leaves the accumulator untouched
        drive(1, 1, 0, 0, 24'h400000, 24'h400000);
        drive(0, 1, 1, 0, 24'h7fffff, 24'h7fffff);
        drive(1, 0, 1, 0, 24'h400000, 24'h400000);
        expect_out(24'h400000, 0);
        idle(LAT + 2);

        // Random plain multiplies with random bubbles
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            model_sample(1, 1, 1, $urandom_range(0, 1) == 1, pick(), pick());
        end
        idle(LAT + 2);

        // Random framing, at most four terms per frame
        begin
            int nf = 0;
            for (int i = 0; i < 300; i++) begin
                bit v, f, l;
                int nn;
                v  = $urandom_range(0, 3) != 0;
                f  = (nf == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                nn = f ? 1 : nf + 1;
                l  = ($urandom_range(0, 2) == 0) || (nn >= 4);
                model_sample(v, f, l, $urandom_range(0, 1) == 1, pick(), pick());
                if (v) nf = l ? 0 : nn;
            end
        end
        idle(LAT + 2);

        // Reset with three samples in flight: all dropped
        model_sample(1, 1, 1, 0, 24'h400000, 24'h400000);
        model_sample(1, 1, 1, 0, 24'h123456, 24'h100000);
        model_sample(1, 1, 1, 1, 24'h7fffff, 24'h400000);
        pulse_reset();
        idle(LAT + 4);
        // accumulator cleared by reset
        model_sample(1, 0, 1, 0, 24'h400000, 24'h400000);
        idle(LAT + 4);

        chk("outstanding results", q.size() == 0, q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
